// File: rtl/ifft_butterfly_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifft_butterfly_pipe_if : streaming handshake/data bundle for the          |
// | inverse radix-2 butterfly.  Revision: 1.0                                 |
// +--------------------------------------------------------------------------+
interface ifft_butterfly_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] W;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sat_flag;
  logic             sat_clr;

  modport master (
    output in_valid, A, B, W, out_ready, sat_clr,
    input  in_ready, out_valid, sum, diff, sat_flag
  );

  modport slave (
    input  in_valid, A, B, W, out_ready, sat_clr,
    output in_ready, out_valid, sum, diff, sat_flag
  );
endinterface
`default_nettype wire

// File: rtl/ifft_butterfly_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifft_butterfly_pipe : 3-stage inverse DIF butterfly, sum=(A+B)/2,         |
// | diff=((A-B)*conj(W))/2 with saturation.  Revision: 1.0                    |
// +--------------------------------------------------------------------------+
module ifft_butterfly_pipe #(
  parameter int WIDTH = 32,
  parameter int HALF  = WIDTH / 2
) (
  input wire                   clk,
  input wire                   rst_n,
  ifft_butterfly_pipe_if.slave bus
);

  localparam int UW = HALF + 1;
  localparam int PW = 2 * HALF + 2;

  logic adv;
  logic s3_load;

  logic signed [HALF-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic signed [PW-1:0]   vre_x, vim_x, wre_x, wim_x, pr_sh, pi_sh;
  logic        [HALF:0]   dre, dim;
  logic                   unused_lsb;

  logic                   s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic                   out_valid_d, out_valid_q, sat_flag_d, sat_flag_q;
  logic signed [UW-1:0]   u_re_d, u_re_q, u_im_d, u_im_q;
  logic signed [UW-1:0]   v_re_d, v_re_q, v_im_d, v_im_q;
  logic        [WIDTH-1:0] w_d, w_q;
  logic signed [UW-1:0]   su_re_d, su_re_q, su_im_d, su_im_q;
  logic signed [PW-1:0]   pr_d, pr_q, pi_d, pi_q;
  logic        [WIDTH-1:0] sum_d, sum_q, diff_d, diff_q;

  // Returns {saturated, value} clipped to the signed HALF-bit range.
  function automatic logic [HALF:0] sat_half(input logic signed [PW-1:0] x);
    logic fits;
    fits = (x[PW-1:HALF-1] == {(PW-HALF+1){x[PW-1]}});
    if (fits) return {1'b0, x[HALF-1:0]};
    else      return {1'b1, x[PW-1], {(HALF-1){~x[PW-1]}}};
  endfunction

  always_comb begin
    adv     = !out_valid_q || bus.out_ready;
    s3_load = adv && s2_valid_q;

    a_re = bus.A[WIDTH-1:HALF];
    a_im = bus.A[HALF-1:0];
    b_re = bus.B[WIDTH-1:HALF];
    b_im = bus.B[HALF-1:0];
    w_re = w_q[WIDTH-1:HALF];
    w_im = w_q[HALF-1:0];

    vre_x = {{(PW-UW){v_re_q[UW-1]}}, v_re_q};
    vim_x = {{(PW-UW){v_im_q[UW-1]}}, v_im_q};
    wre_x = {{(PW-HALF){w_re[HALF-1]}}, w_re};
    wim_x = {{(PW-HALF){w_im[HALF-1]}}, w_im};

    pr_sh = pr_q >>> HALF;
    pi_sh = pi_q >>> HALF;
    dre   = sat_half(pr_sh);
    dim   = sat_half(pi_sh);

    // Halving drops the LSB of u.
    unused_lsb = su_re_q[0] ^ su_im_q[0];

    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    out_valid_d = out_valid_q;
    u_re_d  = u_re_q;
    u_im_d  = u_im_q;
    v_re_d  = v_re_q;
    v_im_d  = v_im_q;
    w_d     = w_q;
    su_re_d = su_re_q;
    su_im_d = su_im_q;
    pr_d    = pr_q;
    pi_d    = pi_q;
    sum_d   = sum_q;
    diff_d  = diff_q;

    if (adv) begin
      s1_valid_d  = bus.in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      u_re_d  = {a_re[HALF-1], a_re} + {b_re[HALF-1], b_re};
      u_im_d  = {a_im[HALF-1], a_im} + {b_im[HALF-1], b_im};
      v_re_d  = {a_re[HALF-1], a_re} - {b_re[HALF-1], b_re};
      v_im_d  = {a_im[HALF-1], a_im} - {b_im[HALF-1], b_im};
      w_d     = bus.W;
      // Multiplying by conj(W) = W_re - j*W_im.
      pr_d    = vre_x * wre_x + vim_x * wim_x;
      pi_d    = vim_x * wre_x - vre_x * wim_x;
      su_re_d = u_re_q;
      su_im_d = u_im_q;
    end

    if (s3_load) begin
      sum_d  = {su_re_q[UW-1:1], su_im_q[UW-1:1]};
      diff_d = {dre[HALF-1:0], dim[HALF-1:0]};
    end

    sat_flag_d = (s3_load && (dre[HALF] || dim[HALF])) || (sat_flag_q && !bus.sat_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      diff_q      <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      diff_q      <= diff_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    u_re_q  <= u_re_d;
    u_im_q  <= u_im_d;
    v_re_q  <= v_re_d;
    v_im_q  <= v_im_d;
    w_q     <= w_d;
    su_re_q <= su_re_d;
    su_im_q <= su_im_d;
    pr_q    <= pr_d;
    pi_q    <= pi_d;
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.diff      = diff_q;
  assign bus.sat_flag  = sat_flag_q;

endmodule
`default_nettype wire

// File: doc/ifft_butterfly_pipe.md
IFFT_BUTTERFLY_PIPE -- requirements
Module: ifft_butterfly_pipe

Interface
REQ-001 Parameter WIDTH, default 32: packed complex word width, {Re[WIDTH-1:HALF], Im[HALF-1:0]}, each half signed Q1.15.
REQ-002 Parameter HALF, default WIDTH/2: component width.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, on the following ports.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  A/B/W are valid this cycle.
REQ-007 in_ready  output  1  block accepts the input this cycle.
REQ-008 A  input  WIDTH  upper input of the inverse (DIF) butterfly, packed {Re,Im}.
REQ-009 B  input  WIDTH  lower input, packed {Re,Im}.
REQ-010 W  input  WIDTH  forward twiddle, packed {Re,Im}; the block conjugates it internally.
REQ-011 out_valid  output  1  sum/diff are valid.
REQ-012 out_ready  input  1  downstream accepts the output.
REQ-013 sum  output  WIDTH  (A+B)/2, packed.
REQ-014 diff  output  WIDTH  ((A-B)*conj(W))/2, packed.
REQ-015 sat_flag  output  1  sticky: some diff component has saturated since reset or the last clear.
REQ-016 sat_clr  input  1  clears sat_flag.

Function
REQ-017 The block SHALL be a 3-stage pipeline: S1 add/sub, S2 complex multiply, S3 scale/saturate/output register.
REQ-018 Each stage SHALL hold a valid bit; out_valid is the S3 valid bit.
REQ-019 Global advance SHALL be adv = !out_valid || out_ready; in_ready = adv, combinationally.
REQ-020 On adv, all stages SHALL shift by one; an input is accepted only when in_valid && in_ready.
REQ-021 When adv=0, all stage registers and valid bits SHALL hold, and sum/diff SHALL stay stable while out_valid=1.
REQ-022 Latency SHALL be 3 cycles from acceptance to out_valid with no backpressure, at a throughput of 1 per cycle.
REQ-023 Bubbles (in_valid=0 on adv) SHALL propagate as invalid slots, without reordering.
REQ-024 S1 SHALL compute, at HALF+1 bits sign-extended, u = A+B and v = A-B per component.
REQ-025 S2 SHALL compute, with 2*HALF+2-bit signed accumulators:
  - pr = v_re*W_re + v_im*W_im
  - pi = v_im*W_re - v_re*W_im
REQ-026 S2 SHALL pass u along unchanged.
REQ-027 S3 SHALL form sum components as u >>> 1 (arithmetic); the result always fits in HALF bits.
REQ-028 S3 SHALL form diff components as pr >>> 16 and pi >>> 16 (15 for Q1.15 plus 1 for the halving), with truncation toward negative infinity.
REQ-029 S3 SHALL saturate each diff component to [-32768, 32767] (0x8000..0x7FFF).
REQ-030 Any diff saturation on an S3 load SHALL set sat_flag on the next edge.
REQ-031 If sat_clr and a new saturation occur in the same cycle, set SHALL win.
REQ-032 W = 0x0000_8000 (-j) SHALL be handled exactly; conj gives +j with no overflow in S2.

Reset
REQ-033 While rst_n=0 at a rising edge, all valid bits, sum, diff and sat_flag SHALL become 0.
REQ-034 During reset, in_ready SHALL follow REQ-019 (1 after the first reset edge).
REQ-035 Reset mid-operation SHALL discard all in-flight data; no out_valid pulse may appear for pre-reset inputs.
REQ-036 Data-path registers other than outputs need no reset; their values are ignored while invalid.

Verification
REQ-037 Identity twiddle: A=0x4000_0000, B=0x2000_0000, W=0x7FFF_0000, out_ready=1 -> 3 cycles later out_valid=1, sum=0x3000_0000, diff=0x0FFF_0000, sat_flag=0.
REQ-038 -j twiddle: A=0x4000_0000, B=0x2000_0000, W=0x0000_8000 -> sum=0x3000_0000, diff=0x0000_1000.
REQ-039 Saturation: A=0x7FFF_7FFF, B=0x8000_8000, W=0x8000_8000 -> diff=0x8000_0000, sum=0xFFFF_FFFF, then sat_flag=1.
REQ-040 sat_flag clear: pulse sat_clr with no new saturation -> sat_flag=0 next cycle.
REQ-041 sat_flag priority: pulse sat_clr in the same cycle as a saturating S3 load -> sat_flag remains 1.
REQ-042 Backpressure: stream 6 vectors with out_ready toggling 1,0,0,1... ->
  - outputs arrive in order, none lost or duplicated;
  - in_ready=0 exactly when out_valid=1 && out_ready=0;
  - sum/diff hold steady during the stall.
REQ-043 Reset flush: accept 2 vectors, assert rst_n=0 for 1 cycle at cycle 2 -> out_valid=0, sum=diff=0 and sat_flag=0 after reset; no output for either vector.
